pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
Sequencer that drives the 4-bit duty-cycle input of the team's 16-clock PWM generator. It accepts commands over a valid/ready handshake: set the duty, ramp it to a target, or run a continuous triangle "breathe" pattern. It keeps a free-running 4-bit frame counter that stays aligned with the PWM's period counter, because both reset together and both count every clk. Duty changes only at PWM frame boundaries, so no glitched or partial periods reach the output.

Parameters:
HOLD_W, 8, width of the per-step hold count (number of extra frames between duty steps).

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  command may be accepted this cycle
cmd_op  input  2  00=SET, 01=RAMP, 10=BREATHE, 11=STOP
cmd_target  input  4  target duty (SET/RAMP) or peak duty (BREATHE)
cmd_hold  input  HOLD_W  step period minus one, in frames
duty  output  4  duty value to the PWM w input
frame_end  output  1  high when frame counter == 15
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when SET/RAMP completes

Behaviour:
- Reset (asynchronous): fcnt=0, duty=0, hcnt=0, hold_reg=0, state=IDLE, done=0, busy=0, cmd_ready=1.
- fcnt increments every clk and wraps 15->0. frame_end = (fcnt==15), combinational from fcnt.
- Accept = cmd_valid & cmd_ready. On accept, latch target and hold_reg=cmd_hold, clear hcnt. The next state is taken the following cycle.
- cmd_ready: 0 only in SET_PEND; 1 in all other states.
- Preemption: an accepted command in RAMP, BR_UP or BR_DN aborts the current operation immediately. No done pulse is issued for the aborted operation. If the accept cycle is also a frame_end, the old operation does not step.
- States: IDLE, SET_PEND, RAMP, BR_UP, BR_DN.
- SET: go to SET_PEND. At the first frame_end strictly after the accept cycle:
  - duty <= target and done = 1, both registered, so visible when fcnt==0;
  - then go to IDLE.
- RAMP:
  - If target == duty at accept: pulse done the next cycle and stay in IDLE.
  - Otherwise go to RAMP.
- Step timing (RAMP, BR_UP, BR_DN): at each frame_end, if hcnt == hold_reg then step and set hcnt <= 0; else hcnt <= hcnt+1. This gives one step every (hold_reg+1) frames.
- RAMP step: duty moves +/-1 toward target. When the new duty equals target, done pulses in the same cycle the duty update becomes visible, and the state goes to IDLE.
- BREATHE, on accept:
  - target==0: treated as STOP.
  - duty < target: go to BR_UP.
  - duty >= target: go to BR_DN.
- BR_UP step: duty+1. On reaching target, go to BR_DN.
- BR_DN step: duty-1. On reaching 0, go to BR_UP.
- BREATHE never asserts done; it exits only via a new command or reset.
- STOP: go to IDLE next cycle, duty frozen, hcnt cleared, no done.
- Arithmetic: duty never wraps; steps are bounded by target, 0 and 15.
- done is exactly one cycle wide; busy is a registered decode of state.
- Reset mid-operation returns every register to its reset value immediately, regardless of state.

Test Plan:
- Reset, then SET target=9 accepted at fcnt=3 -> cmd_ready=0 until the frame_end at fcnt=15; duty=9 and done=1 in the cycle where fcnt=0; back to IDLE with cmd_ready=1.
- From duty=0, RAMP target=3 hold=1 accepted at fcnt=15 -> duty steps 1,2,3 at every 2nd frame_end (32 clk apart); single done pulse with duty=3; busy then low.
- From duty=9, RAMP target=6 hold=0 -> duty 8,7,6 on three consecutive frame_ends; done once. Also RAMP target=duty -> done the next cycle, duty unchanged, busy never high.
- From duty=0, BREATHE target=2 hold=0 -> per-frame duty sequence 1,2,1,0,1,2,1,0; done never asserted; busy held high.
- During BREATHE, STOP on a frame_end cycle -> duty frozen at its pre-stop value, no step that cycle, busy=0 the next cycle, no done.
- Reset asserted mid-RAMP (duty=5, hcnt nonzero) -> duty=0, fcnt=0, state IDLE, done=0 immediately. After release, frame_end first rises 15 clk later.

Source files
------------

// File: rtl/pwm_fade_ctrl_if.sv
// Command channel of the PWM fade sequencer: a valid/ready handshake carrying
// the opcode, the target/peak duty and the per-step hold in frames.
interface pwm_fade_ctrl_if #(
  parameter int HOLD_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [3:0]        cmd_target;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_op, cmd_target, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_target, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle sequencer for the 16-clock PWM generator: SET, RAMP and BREATHE
// commands, with every duty change landing on a PWM frame boundary.
module pwm_fade_ctrl #(
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  pwm_fade_ctrl_if.slave    cmd,
  output logic [3:0]        duty,
  output logic              frame_end,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {OP_SET, OP_RAMP, OP_BREATHE, OP_STOP} op_e;
  typedef enum logic [2:0] {S_IDLE, S_SET_PEND, S_RAMP, S_BR_UP, S_BR_DN} state_e;

  state_e            state_q, state_d;
  logic [3:0]        fcnt_q;
  logic [3:0]        duty_q, duty_d;
  logic [3:0]        target_q, target_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;
  logic              busy_q, ready_q;
  logic              accept;
  logic              step;

  // fcnt_q mirrors the PWM period counter: both reset together and count every clk.
  assign frame_end     = (fcnt_q == 4'd15);
  assign accept        = cmd.cmd_valid & ready_q;
  assign cmd.cmd_ready = ready_q;
  assign duty          = duty_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    hold_d   = hold_q;
    hcnt_d   = hcnt_q;
    done_d   = 1'b0;
    step     = 1'b0;

    if (accept) begin
      // A new command preempts any running operation; the old one never steps.
      target_d = cmd.cmd_target;
      hold_d   = cmd.cmd_hold;
      hcnt_d   = '0;
      case (op_e'(cmd.cmd_op))
        OP_SET:  state_d = S_SET_PEND;
        OP_RAMP: begin
          if (cmd.cmd_target == duty_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RAMP;
          end
        end
        OP_BREATHE: begin
          if (cmd.cmd_target == 4'd0)       state_d = S_IDLE;
          else if (duty_q < cmd.cmd_target) state_d = S_BR_UP;
          else                              state_d = S_BR_DN;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (frame_end) begin
      if (state_q == S_SET_PEND) begin
        duty_d  = target_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else if (state_q inside {S_RAMP, S_BR_UP, S_BR_DN}) begin
        if (hcnt_q == hold_q) begin
          step   = 1'b1;
          hcnt_d = '0;
        end else begin
          hcnt_d = hcnt_q + HOLD_W'(1);
        end
      end
    end

    if (step) begin
      case (state_q)
        S_RAMP: begin
          duty_d = (target_q > duty_q) ? duty_q + 4'd1 : duty_q - 4'd1;
          if (duty_d == target_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BR_UP: begin
          if (duty_q != 4'd15) duty_d = duty_q + 4'd1;
          if (duty_d >= target_q) state_d = S_BR_DN;
        end
        S_BR_DN: begin
          if (duty_q != 4'd0) duty_d = duty_q - 4'd1;
          if (duty_d == 4'd0) state_d = S_BR_UP;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fcnt_q   <= 4'd0;
      duty_q   <= 4'd0;
      target_q <= 4'd0;
      hold_q   <= '0;
      hcnt_q   <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_q + 4'd1;
      duty_q   <= duty_d;
      target_q <= target_d;
      hold_q   <= hold_d;
      hcnt_q   <= hcnt_d;
      done_q   <= done_d;
      busy_q   <= (state_d != S_IDLE);
      ready_q  <= (state_d != S_SET_PEND);
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: a frame-level model predicts duty/done
// events and busy/ready timelines; a negedge monitor compares the DUT to them.
module tb_pwm_fade_ctrl;
  localparam int HOLD_W = 8;
  localparam int MAXC   = 8192;

  typedef struct {
    int cyc;
    int duty;
    bit done;
  } evt_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] duty;
  logic       frame_end, busy, done;

  pwm_fade_ctrl_if #(.HOLD_W(HOLD_W)) cif ();

  pwm_fade_ctrl #(.HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cif),
    .duty      (duty),
    .frame_end (frame_end),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc;
  int   model_duty = 0;
  int   prev_duty = 0;
  evt_t exp_q[$];
  bit   exp_busy[MAXC];
  bit   exp_ready[MAXC];

  // cyc equals the DUT frame counter modulo 16 within each reset epoch.
  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic void fill(input int from, input int to, input bit b, input bit r);
    for (int i = from; i < to && i < MAXC; i++) begin
      exp_busy[i]  = b;
      exp_ready[i] = r;
    end
  endfunction

  // Reference model: duty steps land one cycle after frame_end cycles, every
  // (hold+1) frames, starting with the first frame_end after acceptance.
  task automatic model_accept(input int a, input int op, input int t, input int h);
    int d, f1, s, cur, n;
    bit up;
    while (exp_q.size() > 0 && exp_q[$].cyc > a) void'(exp_q.pop_back());
    d  = (exp_q.size() > 0) ? exp_q[$].duty : model_duty;
    f1 = a - (a % 16) + 15;
    if (f1 == a) f1 += 16;
    fill(a + 1, MAXC, 1'b0, 1'b1);
    case (op)
      0: begin
        exp_q.push_back(evt_t'{f1 + 1, t, 1'b1});
        fill(a + 1, f1 + 1, 1'b1, 1'b0);
      end
      1: begin
        if (t == d) begin
          exp_q.push_back(evt_t'{a + 1, d, 1'b1});
        end else begin
          n = (t > d) ? t - d : d - t;
          s = a;
          for (int k = 1; k <= n; k++) begin
            s   = f1 + (k * (h + 1) - 1) * 16;
            cur = (t > d) ? d + k : d - k;
            exp_q.push_back(evt_t'{s + 1, cur, k == n});
          end
          fill(a + 1, s + 1, 1'b1, 1'b1);
        end
      end
      2: begin
        if (t != 0) begin
          up  = (d < t);
          cur = d;
          fill(a + 1, MAXC, 1'b1, 1'b1);
          for (int k = 1; k < MAXC; k++) begin
            s = f1 + (k * (h + 1) - 1) * 16;
            if (s + 1 >= MAXC) break;
            cur = up ? cur + 1 : cur - 1;
            exp_q.push_back(evt_t'{s + 1, cur, 1'b0});
            if (up && cur == t)       up = 1'b0;
            else if (!up && cur == 0) up = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  // Monitor: any duty change or done pulse is an event to pop and compare.
  always @(negedge clk) begin
    evt_t e;
    if (reset) begin
      prev_duty = 0;
    end else begin
      check("frame_end", frame_end, (cyc % 16) == 15);
      if (cyc < MAXC) begin
        check("busy", busy, exp_busy[cyc]);
        check("cmd_ready", cif.cmd_ready, exp_ready[cyc]);
      end
      if (int'(duty) != prev_duty || done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event cyc=%0d duty=%0d done=%0d", cyc, duty, done);
        end else begin
          e = exp_q.pop_front();
          check("evt_cycle", cyc, e.cyc);
          check("evt_duty", duty, e.duty);
          check("evt_done", done, e.done);
          model_duty = e.duty;
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_event_cycle", cyc + 1, e.cyc);
        model_duty = e.duty;
      end
      prev_duty = duty;
    end
  end

  task automatic sync();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int op, input int t, input int h);
    cif.cmd_valid  = 1'b1;
    cif.cmd_op     = 2'(op);
    cif.cmd_target = 4'(t);
    cif.cmd_hold   = HOLD_W'(h);
    for (int w = 0; w < 200; w++) begin
      if (cif.cmd_ready) begin
        model_accept(cyc, op, t, h);
        @(posedge clk);
        #1;
        cif.cmd_valid = 1'b0;
        return;
      end
      sync();
    end
    cif.cmd_valid = 1'b0;
    check("send_ready_timeout", cif.cmd_ready, 1);
  endtask

  task automatic wait_fcnt(input int n);
    int k = 0;
    while ((cyc % 16) != n && k < 40) begin
      sync();
      k++;
    end
  endtask

  task automatic wait_quiet();
    int k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      sync();
      k++;
    end
    check("quiet_timeout", exp_q.size(), 0);
    repeat (3) sync();
  endtask

  task automatic apply_reset();
    int n;
    #2 reset = 1'b1;
    #1;
    check("rst_duty", duty, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cif.cmd_ready, 1);
    check("rst_frame_end", frame_end, 0);
    exp_q.delete();
    model_duty = 0;
    fill(0, MAXC, 1'b0, 1'b1);
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (frame_end) break;
    end
    check("frame_end_after_reset", n, 15);
    sync();
  endtask

  initial begin
    cif.cmd_valid  = 1'b0;
    cif.cmd_op     = 2'd0;
    cif.cmd_target = 4'd0;
    cif.cmd_hold   = '0;
    fill(0, MAXC, 1'b0, 1'b1);
    repeat (2) sync();
    apply_reset();

    // SET 9 accepted at fcnt=3, then back to 0.
    wait_fcnt(3);
    send(0, 9, 0);
    wait_quiet();
    send(0, 0, 0);
    wait_quiet();

    // RAMP 0->3, hold=1, accepted on a frame_end.
    wait_fcnt(15);
    send(1, 3, 1);
    wait_quiet();

    // RAMP 9->6 hold=0, then RAMP to the current duty.
    send(0, 9, 0);
    wait_quiet();
    send(1, 6, 0);
    wait_quiet();
    send(1, 6, 0);
    wait_quiet();

    // BREATHE peak 2 for eight frames, then STOP on a frame_end.
    send(0, 0, 0);
    wait_quiet();
    send(2, 2, 0);
    repeat (8 * 16) sync();
    wait_fcnt(15);
    send(3, 0, 0);
    repeat (20) sync();

    // Reset in the middle of a slow ramp.
    send(1, 7, 2);
    repeat (16 * 3 * 5 + 20) sync();
    check("pre_reset_duty", duty, model_duty);
    apply_reset();

    // Randomized command stream with preemption.
    for (int i = 0; i < 80; i++) begin
      if (cyc > 6000) apply_reset();
      send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 2));
      repeat ($urandom_range(0, 120)) sync();
    end

    send(3, 0, 0);
    repeat (40) sync();
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
